// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream stage: default data width,
// skid buffer depth and the mod-3 pointer increment.
package fifo_pkg;

  localparam int unsigned FIFO_D_WIDTH  = 16;
  localparam int unsigned RD_SKID_DEPTH = 3;

  // Pointer into the 3-entry skid buffer; only 0..2 are ever used.
  typedef logic [1:0] skid_ptr_t;

  // Advance a skid pointer, wrapping 2 -> 0.
  function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
    skid_ptr_t r;
    if (p == 2'd2) begin
      r = 2'd0;
    end else begin
      r = p + 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 3-entry circular buffer absorbing the FIFO's read latency.
// A word arriving from the FIFO (push_i) is written at wptr; the head at rptr
// is presented on valid_o/data_o and retired when valid_o && ready_i.
// valid_o and data_o are driven only from registers.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_D_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] mem_q [RD_SKID_DEPTH];
  skid_ptr_t     wptr_q, wptr_d;
  skid_ptr_t     rptr_q, rptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign occ_o   = occ_q;
  assign pop     = valid_o && ready_i;

  // Next-state for pointers and occupancy; simultaneous push/pop keeps occ.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push_i) begin
      wptr_d = skid_ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = skid_ptr_inc(rptr_q);
    end
    if (push_i && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push_i && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Buffer storage; written with the FIFO data the cycle after a pop request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (push_i) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains Async_FIFO's read port into a valid/ready stream.
// Credit rule: a pop is requested only while buffered + in-flight words < 3,
// so rd_en never depends on m_ready combinationally.
// Optional feature macro: FIFO_RD_STREAM_CNT_EN (saturating accepted-beat
// counter on words_out; otherwise words_out is tied to 0).
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned d_width = FIFO_D_WIDTH
) (
  input  logic               rd_Clk,
  input  logic               rd_resetn,
  input  logic               fifo_empty,
  input  logic [d_width-1:0] rd_data,
  output logic               rd_en,
  output logic               m_valid,
  output logic [d_width-1:0] m_data,
  input  logic               m_ready,
  output logic               idle,
  output logic [31:0]        words_out
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic [2:0] credit_used;
  logic       pop;

  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign pop         = m_valid && m_ready;

  // Pop request from registered credit state plus the FIFO empty flag.
  always_comb begin
    rd_en      = rd_resetn && !fifo_empty && (credit_used < 3'd3);
    inflight_d = rd_en;
  end

  // Tracks a request whose data lands on rd_data this cycle.
  always_ff @(posedge rd_Clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  rd_skid_buf #(
    .DW (d_width)
  ) u_skid (
    .clk_i       (rd_Clk),
    .rst_ni      (rd_resetn),
    .push_i      (inflight_q),
    .push_data_i (rd_data),
    .ready_i     (m_ready),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .occ_o       (occ)
  );

  assign idle = (occ == 2'd0) && !inflight_q && fifo_empty;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of accepted output beats.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Beat counter register.
  always_ff @(posedge rd_Clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign words_out = cnt_q;
`else
  logic unused_pop;
  assign unused_pop = pop;
  assign words_out  = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a 1-cycle-latency FIFO model.
module tb_fifo_rd_stream;

  logic        rd_Clk = 1'b0;
  logic        rd_resetn;
  logic        fifo_empty;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        idle;
  logic [31:0] words_out;

  fifo_rd_stream #(.d_width(16)) dut (
    .rd_Clk     (rd_Clk),
    .rd_resetn  (rd_resetn),
    .fifo_empty (fifo_empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .idle       (idle),
    .words_out  (words_out)
  );

  always #5 rd_Clk = ~rd_Clk;

  logic [15:0] fq[$];
  logic [15:0] got[$];
  int          beat_cyc[$];
  int          cyc, rden_cnt, nbeats, underflow;
  int          passed, checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_words();
`ifdef FIFO_RD_STREAM_CNT_EN
    return nbeats;
`else
    return 32'd0;
`endif
  endfunction

  // Called at a negedge after inputs are set: samples what the next posedge
  // will see, advances one clock, then updates the FIFO model.
  task automatic tick();
    logic s_rden;
    #1;
    s_rden = rd_en;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      beat_cyc.push_back(cyc);
      nbeats++;
    end
    if (s_rden) rden_cnt++;
    @(posedge rd_Clk);
    #1;
    if (s_rden) begin
      if (fq.size() > 0) rd_data = fq.pop_front();
      else underflow++;
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
    @(negedge rd_Clk);
  endtask

  initial begin
    int r0, k;
    logic [15:0] e;
    passed = 0; checks = 0; cyc = 0; rden_cnt = 0; nbeats = 0; underflow = 0;
    rd_data = '0;
    m_ready = 1'b1;
    rd_resetn = 1'b0;
    fq.push_back(16'd420);
    for (int i = 1; i <= 49; i++) fq.push_back(i[15:0]);
    fifo_empty = 1'b0;

    // Reset with data waiting in the FIFO
    @(negedge rd_Clk);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 16'd0);
    chk("rst_words_out", words_out, 32'd0);
    chk("rst_idle", idle, fifo_empty);
    chk("rst_no_pop", fq.size(), 50);

    // Streaming 50 words
    rd_resetn = 1'b1;
    k = 0;
    while (got.size() < 50 && k < 300) begin tick(); k++; end
    chk("stream_count", got.size(), 50);
    for (int i = 0; i < 50; i++) begin
      e = (i == 0) ? 16'd420 : i[15:0];
      chk("stream_data", got.size() > i ? got[i] : 16'hxxxx, e);
    end
    chk("stream_gap", got.size() == 50 ? beat_cyc[49] - beat_cyc[0] : -1, 49);
    chk("stream_words_out", words_out, exp_words());
    for (int i = 0; i < 3; i++) tick();
    chk("stream_idle", idle, 1'b1);
    chk("stream_underflow", underflow, 0);

    // Backpressure: 10 stalled cycles with a full FIFO
    got.delete(); beat_cyc.delete();
    m_ready = 1'b0;
    fq.push_back(16'd420);
    for (int i = 1; i <= 9; i++) fq.push_back(i[15:0]);
    fifo_empty = 1'b0;
    r0 = rden_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_rd_en_pulses", rden_cnt - r0, 3);
    chk("bp_m_valid", m_valid, 1'b1);
    chk("bp_m_data", m_data, 16'd420);
    chk("bp_no_beats", got.size(), 0);
    m_ready = 1'b1;
    k = 0;
    while (got.size() < 10 && k < 100) begin tick(); k++; end
    for (int i = 0; i < 5; i++) tick();
    chk("bp_count", got.size(), 10);
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 16'd420 : i[15:0];
      chk("bp_data", got.size() > i ? got[i] : 16'hxxxx, e);
    end
    chk("bp_words_out", words_out, exp_words());

    // Empty handling, then a single word for one cycle
    got.delete(); beat_cyc.delete();
    r0 = rden_cnt;
    for (int i = 0; i < 20; i++) tick();
    chk("empty_no_rd_en", rden_cnt - r0, 0);
    fq.push_back(16'd619);
    fifo_empty = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("single_rd_en", rden_cnt - r0, 1);
    chk("single_count", got.size(), 1);
    chk("single_data", got.size() > 0 ? got[0] : 16'hxxxx, 16'd619);
    chk("single_idle", idle, 1'b1);

    // Wrap: 100 words, m_ready pattern 1,0,0 repeating
    got.delete(); beat_cyc.delete();
    for (int i = 1; i <= 100; i++) fq.push_back(16'(2*i + 3*i*i + 5));
    fifo_empty = 1'b0;
    k = 0;
    while (got.size() < 100 && k < 1000) begin
      m_ready = (k % 3 == 0);
      tick();
      k++;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("wrap_count", got.size(), 100);
    for (int i = 1; i <= 100; i++) begin
      e = 16'(2*i + 3*i*i + 5);
      chk("wrap_data", got.size() >= i ? got[i-1] : 16'hxxxx, e);
    end
    chk("wrap_words_out", words_out, exp_words());
    chk("wrap_underflow", underflow, 0);

    // Reset mid-operation with occ=2, inflight=1
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fq.push_back(16'(1000 + i));
    fifo_empty = 1'b0;
    r0 = rden_cnt;
    k = 0;
    while (rden_cnt - r0 < 3 && k < 20) begin tick(); k++; end
    chk("mid_pulses", rden_cnt - r0, 3);
    chk("mid_valid_before", m_valid, 1'b1);
    chk("mid_rd_en_stalled", rd_en, 1'b0);
    rd_resetn = 1'b0;
    #1;
    chk("mid_valid_reset", m_valid, 1'b0);
    chk("mid_data_reset", m_data, 16'd0);
    chk("mid_words_reset", words_out, 32'd0);
    fq.delete();
    fifo_empty = 1'b1;
    rd_data = '0;
    nbeats = 0;
    @(negedge rd_Clk);
    tick(); tick();
    rd_resetn = 1'b1;
    tick(); tick();
    chk("mid_idle", idle, 1'b1);
    chk("mid_valid_after", m_valid, 1'b0);
    chk("mid_words_after", words_out, exp_words());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
